// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Host-side controller for the UART receive path. Holds the LCR/IER/DLL/DLM
//   configuration registers, generates the 16x baud tick from a 16-bit
//   divisor, buffers received bytes, tracks overrun/parity/framing errors and
//   produces a prioritised IIR plus a registered interrupt request.
//
//   Build option: define UART_RX_FIFO_EN to get a DEPTH-entry circular FIFO;
//   otherwise the buffer is a single holding register with a valid bit.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   addr/wr_en/wdata   host register write port
//   addr/rd_en/rdata   host register read port (rdata registered)
//   rx_byte/rx_done    received byte and frame-complete flag from receiver
//   rx_lsr             receiver status (bit2 parity err, bit3 framing err)
//   bclk               baud tick, one-cycle pulse every {DLM,DLL} clocks
//   lcr, ier           configuration outputs to the receiver
//   irq                interrupt request, active-high, registered

module uart_rx_ctrl #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] addr,
    input  logic       wr_en,
    input  logic [7:0] wdata,
    input  logic       rd_en,
    output logic [7:0] rdata,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    input  logic [7:0] rx_lsr,
    output logic       bclk,
    output logic [7:0] lcr,
    output logic [7:0] ier,
    output logic       irq
);

    // DEPTH only matters for the FIFO build, but a bad value is always an error.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_rx_ctrl: DEPTH must be a power of two >= 2");
    end

    // Status bits 0,1 and 4..7 of the receiver are not consumed here.
    logic unused_lsr;
    assign unused_lsr = ^{rx_lsr[7:4], rx_lsr[1:0]};

    logic [7:0]  dll, dlm;
    logic        dlab;
    logic        rd_ok;
    logic        dll_we, dlm_we;
    logic [15:0] divisor, new_div, cnt;

    assign dlab  = lcr[7];
    // A read strobe together with a write is ignored (write wins).
    assign rd_ok = rd_en & ~wr_en;

    // ------------------------------------------------------------------
    // Configuration registers
    // ------------------------------------------------------------------
    assign dll_we = wr_en && addr == 3'd0 && dlab;
    assign dlm_we = wr_en && addr == 3'd1 && dlab;

    always_ff @(posedge clk) begin
        if (reset) begin
            lcr <= 8'h03;
            ier <= 8'h00;
            dll <= 8'h00;
            dlm <= 8'h00;
        end else if (wr_en) begin
            case (addr)
                3'd0: if (dlab) dll <= wdata;
                3'd1: if (dlab) dlm <= wdata; else ier <= wdata;
                3'd3: lcr <= wdata;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Baud generator
    // ------------------------------------------------------------------
    // The counter is loaded with D on a divisor write and counts down to 1;
    // the pulse is registered, so the first tick lands D cycles after the
    // write and then every D cycles.
    assign divisor = {dlm, dll};
    assign new_div = dll_we ? {dlm, wdata} : {wdata, dll};

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 16'd0;
            bclk <= 1'b0;
        end else if (dll_we || dlm_we) begin
            cnt  <= new_div;
            bclk <= 1'b0;
        end else if (divisor == 16'd0) begin
            cnt  <= 16'd0;
            bclk <= 1'b0;
        end else if (cnt <= 16'd1) begin
            cnt  <= divisor;
            bclk <= 1'b1;
        end else begin
            cnt  <= cnt - 16'd1;
            bclk <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection on receiver flags
    // ------------------------------------------------------------------
    logic done_q, pe_in_q, fe_in_q;
    logic push, pe_rise, fe_rise;

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q  <= 1'b0;
            pe_in_q <= 1'b0;
            fe_in_q <= 1'b0;
        end else begin
            done_q  <= rx_done;
            pe_in_q <= rx_lsr[2];
            fe_in_q <= rx_lsr[3];
        end
    end

    assign push    = rx_done   & ~done_q;
    assign pe_rise = rx_lsr[2] & ~pe_in_q;
    assign fe_rise = rx_lsr[3] & ~fe_in_q;

    // ------------------------------------------------------------------
    // Receive buffer
    // ------------------------------------------------------------------
    logic       empty, full, pop, do_push;
    logic [7:0] head;

    // Popping an empty buffer is a no-op; rdata then shows 0x00.
    assign pop     = rd_ok && addr == 3'd0 && !dlab && !empty;
    // A simultaneous pop frees a slot, so a push into a full buffer still fits.
    assign do_push = push && (!full || pop);

`ifdef UART_RX_FIFO_EN
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count;

    assign empty = count == '0;
    assign full  = count == FULL_CNT;
    assign head  = mem[rptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= rx_byte;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
`else
    logic [7:0] hold;
    logic       valid;

    assign empty = !valid;
    assign full  = valid;
    assign head  = hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold  <= 8'h00;
            valid <= 1'b0;
        end else if (do_push) begin
            hold  <= rx_byte;
            valid <= 1'b1;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky line-status errors
    // ------------------------------------------------------------------
    logic oe, pe, fe, lsr_clr, oe_set;

    assign lsr_clr = rd_ok && addr == 3'd5;
    assign oe_set  = push && full && !pop;

    // Clear first, then OR in the set so an event coinciding with the LSR
    // read is not lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            oe <= 1'b0;
            pe <= 1'b0;
            fe <= 1'b0;
        end else begin
            oe <= (oe & ~lsr_clr) | oe_set;
            pe <= (pe & ~lsr_clr) | pe_rise;
            fe <= (fe & ~lsr_clr) | fe_rise;
        end
    end

    // ------------------------------------------------------------------
    // Status, interrupt identification and irq
    // ------------------------------------------------------------------
    logic [7:0] lsr, iir;

    assign lsr = {4'b0000, fe, pe, oe, !empty};

    always_comb begin
        iir = 8'h01;
        if (ier[2] && (oe || pe || fe))
            iir = 8'h06;
        else if (ier[0] && !empty)
            iir = 8'h04;
    end

    always_ff @(posedge clk) begin
        if (reset) irq <= 1'b0;
        else       irq <= ~iir[0];
    end

    // ------------------------------------------------------------------
    // Read data: registered, reflects state before this edge's side effects
    // ------------------------------------------------------------------
    logic [7:0] rd_mux;

    always_comb begin
        rd_mux = 8'h00;
        case (addr)
            3'd0: rd_mux = dlab ? dll : (empty ? 8'h00 : head);
            3'd1: rd_mux = dlab ? dlm : ier;
            3'd2: rd_mux = iir;
            3'd3: rd_mux = lcr;
            3'd5: rd_mux = lsr;
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            rdata <= 8'h00;
        else if (rd_en && wr_en)
            rdata <= 8'h00;
        else if (rd_en)
            rdata <= rd_mux;
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 16;
`ifdef UART_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] addr;
    logic       wr_en, rd_en, rx_done;
    logic [7:0] wdata, rdata, rx_byte, rx_lsr, lcr, ier;
    logic       bclk, irq;

    int checks = 0;
    int failures = 0;

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata), .rx_byte(rx_byte), .rx_done(rx_done),
        .rx_lsr(rx_lsr), .bclk(bclk), .lcr(lcr), .ier(ier), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        addr = a; wdata = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        @(negedge clk);
        addr = a; rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a, input logic [7:0] exp);
        logic [7:0] d;
        rd(a, d);
        chk(tag, {8'h00, d}, {8'h00, exp});
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b; rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    function automatic logic [7:0] ovr_byte(input int i);
        if (CAP == 1) return 8'(8'h11 * (i + 1));
        return 8'(i);
    endfunction

    initial begin
        int pulses, last, pos;
        reset = 1'b1; addr = '0; wr_en = 0; rd_en = 0; wdata = '0;
        rx_byte = '0; rx_done = 0; rx_lsr = '0;

        // Reset defaults
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("rst_rdata", {8'h0, rdata}, 16'h00);
        chk("rst_irq", {15'h0, irq}, 16'h0);
        chk("rst_bclk", {15'h0, bclk}, 16'h0);
        rd_chk("rst_lcr", 3'd3, 8'h03);
        rd_chk("rst_ier", 3'd1, 8'h00);
        rd_chk("rst_iir", 3'd2, 8'h01);
        rd_chk("rst_lsr", 3'd5, 8'h00);

        // Baud tick, divisor 5
        wr(3'd3, 8'h83);
        wr(3'd0, 8'h05);
        wr(3'd1, 8'h00);
        wr(3'd3, 8'h03);
        chk("lcr_port", {8'h0, lcr}, 16'h03);
        pulses = 0; last = -1;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bclk) begin
                if (last >= 0) chk("bclk_period", 16'(c - last), 16'd5);
                last = c;
                pulses++;
            end
        end
        chk("bclk_count", 16'(pulses), 16'd6);

        // Divisor 0 holds bclk low
        wr(3'd3, 8'h83);
        wr(3'd0, 8'h00);
        wr(3'd3, 8'h03);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bclk) pulses++;
        end
        chk("bclk_d0", 16'(pulses), 16'd0);

        // Receive and data-ready interrupt
        wr(3'd1, 8'h01);
        chk("ier_port", {8'h0, ier}, 16'h01);
        push(8'hA5);
        tick();
        chk("irq_dr", {15'h0, irq}, 16'h1);
        rd_chk("lsr_dr", 3'd5, 8'h01);
        rd_chk("iir_dr", 3'd2, 8'h04);
        rd_chk("rbr_a5", 3'd0, 8'hA5);
        rd_chk("lsr_empty", 3'd5, 8'h00);
        rd_chk("iir_none", 3'd2, 8'h01);
        chk("irq_clr", {15'h0, irq}, 16'h0);
        rd_chk("rbr_empty", 3'd0, 8'h00);

        // Ordering and overrun: CAP+1 pushes, the last is dropped
        for (int i = 0; i <= CAP; i++) push(ovr_byte(i));
        rd_chk("lsr_ovr", 3'd5, 8'h03);
        for (int i = 0; i < CAP; i++) rd_chk("rbr_order", 3'd0, ovr_byte(i));
        rd_chk("lsr_after_ovr", 3'd5, 8'h00);
        rd_chk("rbr_dropped", 3'd0, 8'h00);

        // Line status takes priority over data ready
        wr(3'd1, 8'h05);
        push(8'h3C);
        @(negedge clk); rx_lsr[2] = 1'b1;
        tick();
        rd_chk("iir_ls", 3'd2, 8'h06);
        chk("irq_ls", {15'h0, irq}, 16'h1);
        rd_chk("lsr_pe", 3'd5, 8'h05);
        rd_chk("iir_after_lsr", 3'd2, 8'h04);
        rd_chk("rbr_3c", 3'd0, 8'h3C);
        rx_lsr[2] = 1'b0;

        // Error event coinciding with an LSR read: read shows old, set wins
        @(negedge clk);
        addr = 3'd5; rd_en = 1'b1; rx_lsr[3] = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("lsr_pre_set", {8'h0, rdata}, 16'h00);
        rd_chk("lsr_fe", 3'd5, 8'h08);
        rd_chk("lsr_fe_clr", 3'd5, 8'h00);
        rx_lsr[3] = 1'b0;

        // Simultaneous write and read: write lands, read returns 0
        rd_chk("lcr_pre", 3'd3, 8'h03);
        @(negedge clk);
        addr = 3'd3; wdata = 8'h1B; wr_en = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0;
        chk("wr_rd_rdata", {8'h0, rdata}, 16'h00);
        chk("wr_rd_lcr", {8'h0, lcr}, 16'h1B);
        wr(3'd3, 8'h03);

        // Full buffer: push and pop in the same cycle, no overrun
        for (int i = 0; i < CAP; i++) push(8'(8'h40 + i));
        @(negedge clk);
        rx_byte = 8'h99; rx_done = 1'b1; addr = 3'd0; rd_en = 1'b1;
        @(negedge clk);
        rx_done = 1'b0; rd_en = 1'b0;
        chk("full_pop", {8'h0, rdata}, 16'h40);
        rd_chk("full_lsr", 3'd5, 8'h01);
        for (int k = 0; k < CAP; k++)
            rd_chk("full_drain", 3'd0, (k < CAP - 1) ? 8'(8'h41 + k) : 8'h99);
        rd_chk("full_empty", 3'd5, 8'h00);

        // Reset mid-operation
        push(8'h77);
        @(negedge clk); rx_lsr[3] = 1'b1;
        wr(3'd1, 8'h00);
        @(negedge clk); reset = 1'b1; rx_lsr[3] = 1'b0;
        @(negedge clk); reset = 1'b0;
        rd_chk("mid_rst_lsr", 3'd5, 8'h00);
        rd_chk("mid_rst_rbr", 3'd0, 8'h00);
        chk("mid_rst_lcr", {8'h0, lcr}, 16'h03);
        chk("mid_rst_irq", {15'h0, irq}, 16'h0);
        pos = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bclk) pos++;
        end
        chk("mid_rst_bclk", 16'(pos), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
